bus_arb8: RTL and testbench
===========================

BUS_ARB8 -- requirements
Module: bus_arb8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, max consecutive GRANT cycles per tenure while others wait (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port req  input  8  request per requester; req[i] requests mux source i.
REQ-005 SHALL have port gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-006 SHALL have port sel  output  3  registered binary index of the owner; drives the 8:1 8-bit source mux select.
REQ-007 SHALL have port valid  output  1  registered; 1 exactly when gnt is non-zero.

Function
REQ-008 SHALL implement states IDLE, GRANT and SWITCH.
REQ-009 IDLE: if req!=0, the next cycle SHALL be GRANT, with gnt/sel set to the winner; otherwise IDLE.
- Latency: 1 cycle, req to gnt.
REQ-010 Winner SHALL be the first set req bit searching upward from (last+1) mod 8, wrapping 7->0.
- last: index of the most recent owner.
REQ-011 GRANT: hold counter SHALL start at 0 on grant entry and increment each GRANT cycle, saturating at MAX_HOLD-1.
REQ-012 GRANT SHALL go to SWITCH when req[owner]=0.
REQ-013 GRANT SHALL go to SWITCH when the counter equals MAX_HOLD-1 and any other req bit is 1.
REQ-014 At expiry with no other requester, ownership SHALL persist with the counter saturated.
REQ-015 SWITCH SHALL last exactly one cycle with gnt=0, valid=0, sel held at the old owner (bus-turnaround bubble).
- Then GRANT to a new winner (per REQ-010) if req!=0, else IDLE.
REQ-016 On entry to SWITCH, last SHALL be updated to the departing owner.
REQ-017 A requester dropping req for one cycle mid-tenure SHALL lose ownership; no re-grant without re-arbitration.
REQ-018 gnt SHALL never have more than one bit set; sel SHALL equal the index of the gnt bit whenever valid=1.

Reset
REQ-019 While rst_n=0: state=IDLE, gnt=8'h00, sel=3'd0, valid=0, counter=0, last=3'd7.
- First arbitration therefore favours requester 0.
REQ-020 Reset asserted mid-tenure SHALL clear all outputs asynchronously, independent of clk.
REQ-021 After rst_n rises, the first grant SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-022 Macro BUS_ARB8_PRIO0_EN SHALL be supported.
- Defined: requester 0 is fixed highest priority. req[0]=1 wins every arbitration, is exempt from MAX_HOLD expiry, and pre-empts another owner via SWITCH in the cycle after req[0] rises.
- Undefined: requester 0 is an ordinary round-robin participant.

Structure
REQ-023 Shared package bus_arb8_pkg SHALL hold the state enumeration encoding, N_REQ=8, and the index width constant 3.
REQ-024 The combinational rotate-and-priority search SHALL be sub-module rr_pick8 (inputs req, last; outputs found, idx).

Verification
REQ-025 Reset then req=8'h01 -> next cycle gnt=8'h01, sel=0, valid=1.
REQ-026 req=8'h81 held, MAX_HOLD=4, start owner 0 -> gnt 01 for 4 cycles, 1 bubble, gnt 80 for 4 cycles, 1 bubble, repeating.
REQ-027 req=8'h04 only, held 20 cycles -> gnt=8'h04 continuously, no bubble.
REQ-028 Owner 3, req[3] drops while req=8'h30 -> 1 bubble cycle, then gnt=8'h10, sel=4.
REQ-029 rst_n pulsed low mid-grant -> gnt=0, valid=0 immediately; after release with req=8'h80 -> gnt=8'h80.
REQ-030 With BUS_ARB8_PRIO0_EN: owner 5 holding, req[0] rises -> next cycle bubble, following cycle gnt=8'h01.

Source files
------------

// File: rtl/bus_arb8_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb8_pkg
// Shared constants for the 8-requester round-robin bus arbiter:
//   N_REQ      - number of requesters (8)
//   IDX_W      - width of a requester index (3)
//   ST_*       - arbiter FSM state encoding (IDLE, GRANT, SWITCH)
//   onehot8()  - index to one-hot grant vector helper
// -----------------------------------------------------------------------------
package bus_arb8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    // Build the one-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational rotate-and-priority search: returns the first set request bit
// found searching upward from (last+1) mod 8, wrapping 7->0. The search ends
// at 'last' itself, so the previous owner is chosen only if nobody else asks.
// Ports:
//   req   in  [7:0] request vector
//   last  in  [2:0] index of the most recent owner
//   found out       1 when any request bit is set
//   idx   out [2:0] index of the winning requester (don't-care when !found)
// -----------------------------------------------------------------------------
module rr_pick8
    import bus_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_pos;
    logic             w_hit;

    // Walk the eight positions after 'last'; the first hit sticks.
    always_comb begin
        found = 1'b0;
        idx   = last;
        w_pos = last;
        w_hit = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_pos = last + IDX_W'(k);
            w_hit = !found && req[w_pos];
            found = found | w_hit;
            idx   = w_hit ? w_pos : idx;
        end
    end

endmodule

// File: rtl/bus_arb8.sv
// -----------------------------------------------------------------------------
// bus_arb8
// Eight-requester round-robin bus arbiter with a bounded tenure and a one-cycle
// bus-turnaround bubble (SWITCH) between owners.
// Parameter:
//   MAX_HOLD  max consecutive GRANT cycles while others wait (1..15)
// Ports:
//   clk    in        rising-edge clock
//   rst_n  in        asynchronous active-low reset
//   req    in  [7:0] request per requester
//   gnt    out [7:0] registered one-hot grant, zero when no owner
//   sel    out [2:0] registered owner index (mux select); held during SWITCH
//   valid  out       registered, 1 exactly when gnt != 0
// Build option:
//   BUS_ARB8_PRIO0_EN  requester 0 becomes fixed highest priority: it wins
//                      every arbitration, ignores MAX_HOLD expiry and
//                      pre-empts any other owner through SWITCH.
// -----------------------------------------------------------------------------
module bus_arb8
    import bus_arb8_pkg::*;
#(
    parameter int MAX_HOLD = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] sel,
    output logic             valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_sel;
    logic             r_valid;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_last;
    logic             r_armed;

    logic [1:0]       w_state_nx;
    logic [N_REQ-1:0] w_gnt_nx;
    logic [IDX_W-1:0] w_sel_nx;
    logic             w_valid_nx;
    logic [3:0]       w_cnt_nx;
    logic [IDX_W-1:0] w_last_nx;

    logic             w_rr_found;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_preempt;
    logic             w_hold_exempt;
    logic             w_owner_req;
    logic             w_others;
    logic             w_expire;
    logic [3:0]       w_cnt_inc;

    rr_pick8 u_pick (
        .req   (req),
        .last  (r_last),
        .found (w_rr_found),
        .idx   (w_rr_idx)
    );

`ifdef BUS_ARB8_PRIO0_EN
    // Requester 0 overrides the round-robin choice and never times out.
    assign w_win_idx     = req[0] ? {IDX_W{1'b0}} : w_rr_idx;
    assign w_preempt     = req[0] && (r_sel != {IDX_W{1'b0}});
    assign w_hold_exempt = (r_sel == {IDX_W{1'b0}});
`else
    assign w_win_idx     = w_rr_idx;
    assign w_preempt     = 1'b0;
    assign w_hold_exempt = 1'b0;
`endif

    assign w_owner_req = req[r_sel];
    assign w_others    = |(req & ~onehot8(r_sel));
    // Expiry only forces a handover when somebody else is actually waiting.
    assign w_expire    = (r_cnt == HOLD_LAST) && w_others && !w_hold_exempt;
    assign w_cnt_inc   = (r_cnt == HOLD_LAST) ? r_cnt : (r_cnt + 4'd1);

    // Next-state and next-output logic of the IDLE/GRANT/SWITCH machine.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_sel_nx   = r_sel;
        w_valid_nx = r_valid;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        case (r_state)
            ST_IDLE: begin
                // r_armed keeps the first grant off the first edge after reset.
                if (r_armed && w_rr_found) begin
                    w_state_nx = ST_GRANT;
                    w_gnt_nx   = onehot8(w_win_idx);
                    w_sel_nx   = w_win_idx;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = 4'd0;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_gnt_nx   = {N_REQ{1'b0}};
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = 4'd0;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req || w_expire || w_preempt) begin
                    // Bubble cycle: bus released, sel still points at old owner.
                    w_state_nx = ST_SWITCH;
                    w_gnt_nx   = {N_REQ{1'b0}};
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = 4'd0;
                    w_last_nx  = r_sel;
                end else begin
                    w_state_nx = ST_GRANT;
                    w_cnt_nx   = w_cnt_inc;
                end
            end
            ST_SWITCH: begin
                if (w_rr_found) begin
                    w_state_nx = ST_GRANT;
                    w_gnt_nx   = onehot8(w_win_idx);
                    w_sel_nx   = w_win_idx;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = 4'd0;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_gnt_nx   = {N_REQ{1'b0}};
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = 4'd0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = {N_REQ{1'b0}};
                w_valid_nx = 1'b0;
                w_cnt_nx   = 4'd0;
            end
        endcase
    end

    // State and output registers; last resets to 7 so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= {N_REQ{1'b0}};
            r_sel   <= {IDX_W{1'b0}};
            r_valid <= 1'b0;
            r_cnt   <= 4'd0;
            r_last  <= 3'd7;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_sel   <= w_sel_nx;
            r_valid <= w_valid_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_last_nx;
            r_armed <= 1'b1;
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;

endmodule

// File: tb/tb_bus_arb8.sv
// -----------------------------------------------------------------------------
// tb_bus_arb8
// Directed-vector bench for bus_arb8 with MAX_HOLD=4. Each task drives one
// scenario and compares gnt/sel/valid against hand-derived values.
// -----------------------------------------------------------------------------
module tb_bus_arb8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arb8 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and spend the arming edge with no requests.
    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        req   = 8'hFF;
        #3;
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        n_vec++;
        if (sel !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel); end
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        step();
        step();
        n_vec++;
        if (valid !== 1'b0 || gnt !== 8'h00) begin
            n_err++; $display("FAIL reset_held: got gnt %h valid %b want 00/0", gnt, valid);
        end
        // Release with req[0] already up: no grant on the first edge.
        req   = 8'h01;
        rst_n = 1'b1;
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_first_edge: got valid %b want 0", valid); end
        step();
        n_vec++;
        if (gnt !== 8'h01 || sel !== 3'd0 || valid !== 1'b1) begin
            n_err++; $display("FAIL reset_second_edge: got gnt %h sel %0d valid %b want 01/0/1", gnt, sel, valid);
        end
    endtask

    task automatic test_first_grant();
        do_reset();
        req = 8'h01;
        step();
        n_vec++;
        if (gnt !== 8'h01 || sel !== 3'd0 || valid !== 1'b1) begin
            n_err++; $display("FAIL first_grant: got gnt %h sel %0d valid %b want 01/0/1", gnt, sel, valid);
        end
    endtask

    task automatic test_rr_two();
        int         ph;
        logic [7:0] exp_g;
        logic [2:0] exp_s;
        do_reset();
        req = 8'h81;
        for (int i = 0; i < 20; i++) begin
            step();
            ph    = i % 10;
            exp_g = (ph < 4) ? 8'h01 : (ph == 4) ? 8'h00 : (ph < 9) ? 8'h80 : 8'h00;
            exp_s = (ph < 5) ? 3'd0 : 3'd7;
            n_vec++;
            if (gnt !== exp_g || sel !== exp_s || valid !== (exp_g != 8'h00)) begin
                n_err++;
                $display("FAIL rr_two cyc %0d: got gnt %h sel %0d valid %b want %h/%0d/%b",
                         i, gnt, sel, valid, exp_g, exp_s, (exp_g != 8'h00));
            end
        end
        req = 8'h00;
    endtask

    task automatic test_rr_three();
        logic [2:0] own [3] = '{3'd0, 3'd2, 3'd5};
        logic [7:0] exp_g;
        int         ph;
        do_reset();
        req = 8'h25;
        for (int i = 0; i < 16; i++) begin
            step();
            ph    = i % 15;
            exp_g = ((ph % 5) < 4) ? (8'h01 << own[ph / 5]) : 8'h00;
            n_vec++;
            if (gnt !== exp_g || valid !== (exp_g != 8'h00)) begin
                n_err++;
                $display("FAIL rr_three cyc %0d: got gnt %h valid %b want %h", i, gnt, valid, exp_g);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h04;
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (gnt !== 8'h04 || sel !== 3'd2 || valid !== 1'b1) begin
                n_err++;
                $display("FAIL single cyc %0d: got gnt %h sel %0d valid %b want 04/2/1", i, gnt, sel, valid);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_drop();
        do_reset();
        req = 8'h08;
        step();
        n_vec++;
        if (gnt !== 8'h08 || sel !== 3'd3) begin
            n_err++; $display("FAIL drop_owner3: got gnt %h sel %0d want 08/3", gnt, sel);
        end
        req = 8'h30;
        step();
        n_vec++;
        if (gnt !== 8'h00 || valid !== 1'b0 || sel !== 3'd3) begin
            n_err++; $display("FAIL drop_bubble: got gnt %h sel %0d valid %b want 00/3/0", gnt, sel, valid);
        end
        step();
        n_vec++;
        if (gnt !== 8'h10 || sel !== 3'd4 || valid !== 1'b1) begin
            n_err++; $display("FAIL drop_next: got gnt %h sel %0d valid %b want 10/4/1", gnt, sel, valid);
        end
        req = 8'h00;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h04;
        step();
        n_vec++;
        if (gnt !== 8'h04) begin n_err++; $display("FAIL areset_pre: got gnt %h want 04", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (gnt !== 8'h00 || valid !== 1'b0 || sel !== 3'd0) begin
            n_err++; $display("FAIL areset_now: got gnt %h sel %0d valid %b want 00/0/0", gnt, sel, valid);
        end
        step();
        rst_n = 1'b1;
        req   = 8'h80;
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL areset_arm: got valid %b want 0", valid); end
        step();
        n_vec++;
        if (gnt !== 8'h80 || sel !== 3'd7 || valid !== 1'b1) begin
            n_err++; $display("FAIL areset_after: got gnt %h sel %0d valid %b want 80/7/1", gnt, sel, valid);
        end
        req = 8'h00;
    endtask

    task automatic test_prio0();
`ifdef BUS_ARB8_PRIO0_EN
        logic [7:0] exp_seq [7] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
`else
        logic [7:0] exp_seq [7] = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h01, 8'h01, 8'h01};
`endif
        do_reset();
        req = 8'h20;
        step();
        n_vec++;
        if (gnt !== 8'h20 || sel !== 3'd5) begin
            n_err++; $display("FAIL prio0_owner5: got gnt %h sel %0d want 20/5", gnt, sel);
        end
        req = 8'h21;
        for (int i = 0; i < 7; i++) begin
            step();
            n_vec++;
            if (gnt !== exp_seq[i] || valid !== (exp_seq[i] != 8'h00)) begin
                n_err++;
                $display("FAIL prio0 cyc %0d: got gnt %h valid %b want %h", i, gnt, valid, exp_seq[i]);
            end
        end
        req = 8'h00;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 8'h00;
        test_reset();
        test_first_grant();
        test_rr_two();
        test_rr_three();
        test_single();
        test_drop();
        test_async_reset();
        test_prio0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
